// File: rtl/clockworks.sv
// clockworks: derives the SoC system clock from the board oscillator and
// produces a glitch-free, synchronous, active-low system reset that is held
// for HOLD_CYCLES clk edges after configuration and after every button release.
// There is no reset input: every flop starts from its configuration value.
module clockworks #(
   parameter int SLOW              = 19,
   parameter int HOLD_CYCLES       = 16,
   parameter bit RESET_ACTIVE_HIGH = 1'b1
) (
   input  logic CLK,
   input  logic RESET,
   output logic clk,
   output logic resetn
);

   // Last hold count value; reaching it releases the reset.
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

   generate
      if (SLOW > 0) begin : g_div
         logic [SLOW-1:0] div_cnt = '0;

         // Free-running divider, wraps naturally, never reset.
         always_ff @(posedge CLK) begin
            div_cnt <= div_cnt + SLOW'(1);
         end

         // Clock taken straight from a flop: 50% duty, no glitches.
         assign clk = div_cnt[SLOW-1];
      end else begin : g_nodiv
         assign clk = CLK;
      end
   endgenerate

   // Button normalised to active-high regardless of board wiring.
   logic rst_btn;
   assign rst_btn = RESET_ACTIVE_HIGH ? RESET : ~RESET;

   logic        rst_meta   = 1'b0;
   logic        rst_sync   = 1'b0;
   logic [15:0] hold_cnt   = 16'd0;
   logic        resetn_reg = 1'b0;

   // Two-flop synchroniser bringing the asynchronous button into clk.
   always_ff @(posedge clk) begin
      rst_meta <= rst_btn;
      rst_sync <= rst_meta;
   end

   // Hold counter: restarts on every button sample, saturates at the end of
   // the hold window, and only then lets the reset go.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         hold_cnt   <= 16'd0;
         resetn_reg <= 1'b0;
      end else if (hold_cnt < HOLD_LAST) begin
         hold_cnt   <= hold_cnt + 16'd1;
         resetn_reg <= 1'b0;
      end else begin
         resetn_reg <= 1'b1;
      end
   end

   assign resetn = resetn_reg;

endmodule

// File: tb/tb_clockworks.sv
// Scoreboard bench for clockworks: the stimulus process pushes expected
// resetn values keyed by clk edge number; a monitor on the falling clk edge
// pops and compares. A separate process checks the generated clock waveforms.
module tb_clockworks;

   logic CLK;
   logic reset_main, reset_low, reset_fast;
   logic clk_main, clk_low, clk_fast;
   logic resetn_main, resetn_low, resetn_fast;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_cnt = 0;

   typedef struct {
      int   e;
      bit   which;   // 0 = main instance, 1 = active-low instance
      logic v;
   } exp_t;

   exp_t exp_q[$];

   clockworks #(.SLOW(2), .HOLD_CYCLES(16), .RESET_ACTIVE_HIGH(1'b1)) u_main (
      .CLK(CLK), .RESET(reset_main), .clk(clk_main), .resetn(resetn_main));

   clockworks #(.SLOW(2), .HOLD_CYCLES(16), .RESET_ACTIVE_HIGH(1'b0)) u_low (
      .CLK(CLK), .RESET(reset_low), .clk(clk_low), .resetn(resetn_low));

   clockworks #(.SLOW(0), .HOLD_CYCLES(16), .RESET_ACTIVE_HIGH(1'b1)) u_fast (
      .CLK(CLK), .RESET(reset_fast), .clk(clk_fast), .resetn(resetn_fast));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Count rising edges of the generated system clock.
   always @(posedge clk_main) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end else begin
         $display("ok   %s: %b", name, act);
      end
   endtask

   // Sorted insert so expectations may be pushed in any order.
   function automatic void push(input int e, input bit which, input logic v);
      exp_t it;
      int   i;
      it.e = e; it.which = which; it.v = v;
      i = exp_q.size();
      while (i > 0 && exp_q[i-1].e > e) i--;
      exp_q.insert(i, it);
   endfunction

   task automatic wait_edge(input int target);
      int guard = 0;
      while (edge_cnt < target) begin
         @(posedge clk_main);
         #1;
         guard++;
         if (guard > 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_edge: at edge %0d, required edge %0d", edge_cnt, target);
            return;
         end
      end
   endtask

   // Monitor: every clk edge presents a new resetn; compare pending entries.
   initial begin
      exp_t it;
      forever begin
         @(negedge clk_main);
         while (exp_q.size() > 0 && exp_q[0].e <= edge_cnt) begin
            it = exp_q.pop_front();
            if (it.e < edge_cnt) begin
               n_checks++;
               n_fail++;
               $display("FAIL missed_edge: expectation for edge %0d seen at edge %0d", it.e, edge_cnt);
            end else begin
               check($sformatf("edge %0d %s resetn", it.e, it.which ? "low" : "main"),
                     it.which ? resetn_low : resetn_main, it.v);
            end
         end
      end
   end

   // Clock waveform checks: divided clock pattern and pass-through clock.
   initial begin
      #1;
      check("clk_main before first edge", clk_main, 1'b0);
      check("clk_fast low phase 0", clk_fast, 1'b0);
      for (int n = 1; n <= 16; n++) begin
         @(posedge CLK);
         #1;
         check($sformatf("clk_main after CLK edge %0d", n), clk_main, ((n % 4) >= 2) ? 1'b1 : 1'b0);
         check($sformatf("clk_fast high phase %0d", n), clk_fast, 1'b1);
         if (n == 15) check("resetn_fast after edge 15", resetn_fast, 1'b0);
         if (n == 16) check("resetn_fast after edge 16", resetn_fast, 1'b1);
         @(negedge CLK);
         #1;
         check($sformatf("clk_fast low phase %0d", n), clk_fast, 1'b0);
      end
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      int e0, e, f, f1, e2, f2;
      reset_main = 1'b0;
      reset_low  = 1'b1;
      reset_fast = 1'b0;
      #1;
      check("reset state main", resetn_main, 1'b0);
      check("reset state low", resetn_low, 1'b0);
      check("reset state fast", resetn_fast, 1'b0);

      // Power-up: low through edge 15, high from edge 16, stays high.
      for (int k = 1; k <= 16; k++) begin
         push(k, 1'b0, (k >= 16) ? 1'b1 : 1'b0);
         push(k, 1'b1, (k >= 16) ? 1'b1 : 1'b0);
      end
      for (int k = 17; k <= 1016; k++) push(k, 1'b0, 1'b1);
      for (int k = 17; k <= 20; k++) push(k, 1'b1, 1'b1);
      wait_edge(1016);

      // Button held for 3 edges.
      e0 = edge_cnt;
      reset_main = 1'b1;
      e = e0 + 1;
      push(e + 2, 1'b0, 1'b0);
      wait_edge(e0 + 3);
      reset_main = 1'b0;
      f = e0 + 4;
      push(f + 16, 1'b0, 1'b0);
      push(f + 17, 1'b0, 1'b1);
      push(f + 40, 1'b0, 1'b1);
      wait_edge(f + 40);

      // Re-press 5 edges after release restarts the hold window.
      e0 = edge_cnt;
      reset_main = 1'b1;
      push(e0 + 3, 1'b0, 1'b0);
      wait_edge(e0 + 3);
      reset_main = 1'b0;
      f1 = e0 + 4;
      wait_edge(f1 + 4);
      reset_main = 1'b1;
      e2 = f1 + 5;
      push(e2 + 2, 1'b0, 1'b0);
      push(f1 + 17, 1'b0, 1'b0);
      wait_edge(e2 + 2);
      reset_main = 1'b0;
      f2 = e2 + 3;
      push(f2 + 16, 1'b0, 1'b0);
      push(f2 + 17, 1'b0, 1'b1);
      wait_edge(f2 + 20);

      // Pulse spanning exactly two edges still resets.
      e0 = edge_cnt;
      reset_main = 1'b1;
      e = e0 + 1;
      wait_edge(e0 + 2);
      reset_main = 1'b0;
      f = e0 + 3;
      push(e + 2, 1'b0, 1'b0);
      push(f + 16, 1'b0, 1'b0);
      push(f + 17, 1'b0, 1'b1);
      push(f + 17, 1'b1, 1'b1);
      wait_edge(f + 20);

      // Active-low button instance.
      e0 = edge_cnt;
      reset_low = 1'b0;
      e = e0 + 1;
      push(e + 2, 1'b1, 1'b0);
      wait_edge(e0 + 3);
      reset_low = 1'b1;
      f = e0 + 4;
      push(f + 16, 1'b1, 1'b0);
      push(f + 17, 1'b1, 1'b1);
      wait_edge(f + 19);
      #25;

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/clockworks.md
CLOCKWORKS -- requirements
Module: clockworks

Interface
REQ-001 SHALL have parameter SLOW, default 19: clock divider exponent; the generated clk period is 2^SLOW CLK periods; 0 means no division.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: number of clk rising edges resetn is held low after power-up or after button release; legal range is 1 to 2^16-1.
REQ-003 SHALL have parameter RESET_ACTIVE_HIGH, default 1: polarity of the RESET button input (1 = pressed-high).
REQ-004 CLK  input  1  board oscillator clock; the only free-running input clock.
REQ-005 RESET  input  1  reset button; asynchronous to everything; polarity set by RESET_ACTIVE_HIGH.
REQ-006 clk  output  1  system clock generated for the rest of the SoC.
REQ-007 resetn  output  1  system reset for the SoC.
REQ-008 Reset resetn SHALL be synchronous and active-low; clock clk.

Function
REQ-009 SHALL contain a free-running SLOW-bit counter div_cnt, incremented on every CLK rising edge, wrapping from 2^SLOW-1 to 0 with no reset.
REQ-010 When SLOW>0, clk SHALL equal div_cnt[SLOW-1]: 50% duty cycle, period 2^SLOW CLK cycles, glitch-free because it is taken directly from a flop.
REQ-011 When SLOW=0, clk SHALL be CLK passed through combinationally and no divider flops SHALL exist.
REQ-012 The RESET input SHALL be normalised to active-high (rst_btn) according to RESET_ACTIVE_HIGH.
REQ-013 rst_btn SHALL be synchronised into the clk domain by a two-flop synchroniser (rst_meta, then rst_sync), clocked on clk rising edges.
REQ-014 The block SHALL hold a 16-bit hold counter hold_cnt and a registered resetn, both updated only on clk rising edges.
REQ-015 Per clk edge, case rst_sync=1: hold_cnt is set to 0 and resetn to 0.
REQ-016 Per clk edge, case rst_sync=0 and hold_cnt < HOLD_CYCLES-1: hold_cnt increments and resetn is set to 0.
REQ-017 Per clk edge, case rst_sync=0 and hold_cnt = HOLD_CYCLES-1: hold_cnt holds its value (saturates) and resetn is set to 1.
REQ-018 resetn SHALL never glitch; it changes only on clk rising edges.
REQ-019 Button assertion latency: RESET pressed and first sampled at clk edge e SHALL give resetn=0 after edge e+2 at the latest.
REQ-020 Button release: RESET released and first sampled at edge f SHALL give resetn=1 after edge f+1+HOLD_CYCLES, provided the button is not re-pressed.
REQ-021 A re-press during the hold window SHALL restart the full HOLD_CYCLES count from 0.
REQ-022 A pulse shorter than one clk period may be missed; any pulse spanning at least 2 clk rising edges SHALL produce a reset.
REQ-023 No counter SHALL overflow; hold_cnt saturates and div_cnt wraps by design.

Reset
REQ-024 The block has no reset input of its own; all flops SHALL use FPGA configuration initial values.
REQ-025 Initial values: div_cnt=0, rst_meta=0, rst_sync=0, hold_cnt=0, resetn=0.
REQ-026 After configuration with the button released, resetn SHALL stay 0 for exactly HOLD_CYCLES clk edges and rise at edge HOLD_CYCLES. This covers the iCE40 BRAM-not-ready-after-configuration window.
REQ-027 resetn SHALL remain 1 indefinitely thereafter unless the button is pressed.

Verification
REQ-028 SLOW=2, free-running CLK -> clk is 0 for 2 CLK cycles then 1 for 2 CLK cycles, with its first rising edge after the 2nd CLK rising edge (div_cnt 01->10).
REQ-029 SLOW=0 -> clk identical to CLK at every sample.
REQ-030 SLOW=2, HOLD_CYCLES=16, RESET idle from time 0 -> resetn=0 through clk edge 15, resetn=1 after clk edge 16, and it remains 1 for 1000 further clk edges.
REQ-031 Steady state, RESET held active for 3 clk edges starting at edge e -> resetn=0 after edge e+2; release first sampled at edge f -> resetn=1 after edge f+17 (HOLD_CYCLES=16).
REQ-032 RESET re-pressed 5 clk edges after release -> hold_cnt returns to 0; resetn high exactly 17 edges after the second release sample.
REQ-033 RESET_ACTIVE_HIGH=0 with RESET held at 1 (not pressed) -> same power-up sequence as REQ-030; driving RESET to 0 triggers reset as in REQ-031.
